notepad_cursor_ctrl: RTL and testbench

- Sequencer between the PS/2 scancode path and the shared character framebuffer of the notepad.
- Consumes one scancode byte per strobe and filters break (F0) and extended (E0) prefixes.
- Tracks the text cursor and issues req/ack-handshaked character writes into the framebuffer, which is shared with the VGA reader.
- The ASCII translation of each byte is supplied alongside it by the existing scancode-to-ASCII translator.

---
 rtl/notepad_cursor_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_notepad_cursor_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/notepad_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// notepad_cursor_ctrl
//
// Sits between the PS/2 scancode path and the character framebuffer that the
// notepad shares with the VGA reader. It accepts one scancode byte per strobe
// and filters out the break (F0) and extended (E0) prefixes. It tracks the
// text cursor and issues req/ack-handshaked character writes.
//
// Optional feature: define NOTEPAD_CLEAR_ON_ESC_EN to make ESC (0x76) clear the
// whole screen to spaces. The clear writes one address per ack and then homes
// the cursor.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   scan_valid in   one-cycle strobe, scan_data/ascii_in valid
//   scan_data  in   PS/2 scancode byte
//   ascii_in   in   ASCII translation of scan_data (same cycle)
//   scan_ready out  a byte can be accepted this cycle
//   scan_drop  out  one-cycle pulse: a byte arrived while scan_ready was low
//   wr_req     out  framebuffer write request
//   wr_addr    out  write address (row*COLS+col)
//   wr_data    out  ASCII character to write
//   wr_ack     in   arbiter grant; write completes when wr_req && wr_ack
//   cur_row    out  cursor row
//   cur_col    out  cursor column
// ---------------------------------------------------------------------------
module notepad_cursor_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scan_valid,
  input  logic [7:0]        scan_data,
  input  logic [6:0]        ascii_in,
  output logic              scan_ready,
  output logic              scan_drop,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  input  logic              wr_ack,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BRK     = 3'd1,
    S_EXT     = 3'd2,
    S_EXT_BRK = 3'd3,
`ifdef NOTEPAD_CLEAR_ON_ESC_EN
    S_WRITE   = 3'd4,
    S_CLEAR   = 3'd5
`else
    S_WRITE   = 3'd4
`endif
  } state_t;

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  // Linear framebuffer address, computed at full ADDR_W width.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return (ADDR_W'(r) * ADDR_W'(COLS)) + ADDR_W'(c);
  endfunction

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  // Cursor position to adopt once the pending write is acknowledged.
  logic [ROW_W-1:0]   pend_row_q, pend_row_d;
  logic [COL_W-1:0]   pend_col_q, pend_col_d;
  logic               wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [6:0]         wr_data_q, wr_data_d;
  logic               scan_ready_q, scan_ready_d;
  logic               scan_drop_q, scan_drop_d;

  logic [ROW_W-1:0]   row_inc_s;
  logic               printable_s;

  // Row successor with wrap, and the printable-key test.
  always_comb begin
    if (cur_row_q == ROW_MAX) begin
      row_inc_s = {ROW_W{1'b0}};
    end else begin
      row_inc_s = cur_row_q + ROW_W'(1);
    end
    printable_s = (scan_data == 8'h29) || (ascii_in != 7'h20);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    pend_row_d   = pend_row_q;
    pend_col_d   = pend_col_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    scan_drop_d  = scan_valid && !scan_ready_q;
    scan_ready_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (scan_valid) begin
          if (scan_data == 8'hF0) begin
            state_d = S_BRK;
          end else if (scan_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (scan_data == 8'h66) begin
            // Backspace: erase the predecessor cell and move onto it.
            // At the home cell the space is still written at (0,0).
            if (cur_col_q != {COL_W{1'b0}}) begin
              pend_row_d = cur_row_q;
              pend_col_d = cur_col_q - COL_W'(1);
            end else if (cur_row_q != {ROW_W{1'b0}}) begin
              pend_row_d = cur_row_q - ROW_W'(1);
              pend_col_d = COL_MAX;
            end else begin
              pend_row_d = {ROW_W{1'b0}};
              pend_col_d = {COL_W{1'b0}};
            end
            wr_addr_d = cell_addr(pend_row_d, pend_col_d);
            wr_data_d = 7'h20;
            wr_req_d  = 1'b1;
            state_d   = S_WRITE;
          end else if (scan_data == 8'h5A) begin
            cur_col_d = {COL_W{1'b0}};
            cur_row_d = row_inc_s;
          end else if (scan_data == 8'h76) begin
`ifdef NOTEPAD_CLEAR_ON_ESC_EN
            wr_addr_d = {ADDR_W{1'b0}};
            wr_data_d = 7'h20;
            wr_req_d  = 1'b1;
            state_d   = S_CLEAR;
`else
            // ESC has no function without the clear feature.
            state_d = S_IDLE;
`endif
          end else if (printable_s) begin
            wr_addr_d = cell_addr(cur_row_q, cur_col_q);
            wr_data_d = ascii_in;
            wr_req_d  = 1'b1;
            if (cur_col_q == COL_MAX) begin
              pend_col_d = {COL_W{1'b0}};
              pend_row_d = row_inc_s;
            end else begin
              pend_col_d = cur_col_q + COL_W'(1);
              pend_row_d = cur_row_q;
            end
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BRK, S_EXT_BRK: begin
        // The released key's code carries no action.
        if (scan_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      S_EXT: begin
        if (scan_valid) begin
          state_d = S_IDLE;
          case (scan_data)
            8'hF0: state_d = S_EXT_BRK;
            8'h6B: begin
              if (cur_col_q != {COL_W{1'b0}}) begin
                cur_col_d = cur_col_q - COL_W'(1);
              end else begin
                cur_col_d = cur_col_q;
              end
            end
            8'h74: begin
              if (cur_col_q != COL_MAX) begin
                cur_col_d = cur_col_q + COL_W'(1);
              end else begin
                cur_col_d = cur_col_q;
              end
            end
            8'h75: begin
              if (cur_row_q != {ROW_W{1'b0}}) begin
                cur_row_d = cur_row_q - ROW_W'(1);
              end else begin
                cur_row_d = cur_row_q;
              end
            end
            8'h72: begin
              if (cur_row_q != ROW_MAX) begin
                cur_row_d = cur_row_q + ROW_W'(1);
              end else begin
                cur_row_d = cur_row_q;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_EXT;
        end
      end

      S_WRITE: begin
        // Address and data stay put until the arbiter grants.
        if (wr_ack) begin
          wr_req_d  = 1'b0;
          cur_row_d = pend_row_q;
          cur_col_d = pend_col_q;
          state_d   = S_IDLE;
        end else begin
          wr_req_d = 1'b1;
        end
      end

`ifdef NOTEPAD_CLEAR_ON_ESC_EN
      S_CLEAR: begin
        if (wr_ack) begin
          if (wr_addr_q == LAST_ADDR) begin
            wr_req_d  = 1'b0;
            cur_row_d = {ROW_W{1'b0}};
            cur_col_d = {COL_W{1'b0}};
            state_d   = S_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end else begin
          wr_req_d = 1'b1;
        end
      end
`endif

      default: begin
        wr_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // scan_ready is registered, so derive it from the state being entered.
`ifdef NOTEPAD_CLEAR_ON_ESC_EN
    if ((state_d == S_WRITE) || (state_d == S_CLEAR)) begin
      scan_ready_d = 1'b0;
    end else begin
      scan_ready_d = 1'b1;
    end
`else
    if (state_d == S_WRITE) begin
      scan_ready_d = 1'b0;
    end else begin
      scan_ready_d = 1'b1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cur_row_q    <= {ROW_W{1'b0}};
      cur_col_q    <= {COL_W{1'b0}};
      pend_row_q   <= {ROW_W{1'b0}};
      pend_col_q   <= {COL_W{1'b0}};
      wr_req_q     <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= 7'h00;
      scan_ready_q <= 1'b1;
      scan_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      pend_row_q   <= pend_row_d;
      pend_col_q   <= pend_col_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      scan_ready_q <= scan_ready_d;
      scan_drop_q  <= scan_drop_d;
    end
  end

  assign scan_ready = scan_ready_q;
  assign scan_drop  = scan_drop_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;

endmodule

// File: tb/tb_notepad_cursor_ctrl.sv
// Directed testbench for notepad_cursor_ctrl (default 80x60 geometry).
module tb_notepad_cursor_ctrl;

  logic        clk;
  logic        resetn;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic [6:0]  ascii_in;
  logic        scan_ready;
  logic        scan_drop;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [6:0]  wr_data;
  logic        wr_ack;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;

  int checks = 0;
  int errors = 0;

  // Handshake monitor: counts completed writes and remembers the last one.
  int          wr_count = 0;
  logic [12:0] last_addr = 13'd0;
  logic [6:0]  last_data = 7'd0;
  int          clr_next = 0;
  int          clr_bad  = 0;

  notepad_cursor_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .scan_valid(scan_valid),
    .scan_data (scan_data),
    .ascii_in  (ascii_in),
    .scan_ready(scan_ready),
    .scan_drop (scan_drop),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn && wr_req && wr_ack) begin
      wr_count  = wr_count + 1;
      last_addr = wr_addr;
      last_data = wr_data;
      if ((int'(wr_addr) != clr_next) || (wr_data != 7'h20)) clr_bad = clr_bad + 1;
      clr_next = int'(wr_addr) + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    scan_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Present one byte for one cycle; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input logic [6:0] a);
    scan_valid = 1'b1;
    scan_data  = b;
    ascii_in   = a;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reset and walk the cursor to (r,c) using enter and right-arrow keys.
  task automatic go_to(input int r, input int c);
    do_reset();
    for (int i = 0; i < r; i++) send_byte(8'h5A, 7'h0D);
    for (int i = 0; i < c; i++) begin
      send_byte(8'hE0, 7'h20);
      send_byte(8'h74, 7'h20);
    end
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    checks++;
    if ((cur_row !== 6'(r)) || (cur_col !== 7'(c))) begin
      errors++;
      $display("FAIL %s: cursor got (%0d,%0d) expected (%0d,%0d)", name, cur_row, cur_col, r, c);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_req, wr_addr, wr_data, scan_ready, scan_drop} !== {1'b0, 13'd0, 7'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b addr=%0d data=%0h rdy=%0b drop=%0b expected 0 0 0 1 0",
               wr_req, wr_addr, wr_data, scan_ready, scan_drop);
    end
    check_cursor("reset_cursor", 0, 0);
  endtask

  task automatic test_basic();
    int base;
    wr_ack = 1'b1;
    do_reset();
    base = wr_count;
    send_byte(8'h1C, 7'h41);
    checks++;
    if ((wr_req !== 1'b1) || (scan_ready !== 1'b0)) begin
      errors++;
      $display("FAIL latency_req: req=%0b rdy=%0b expected 1 0", wr_req, scan_ready);
    end
    @(negedge clk);
    checks++;
    if ((wr_req !== 1'b0) || (wr_count - base != 1)) begin
      errors++;
      $display("FAIL latency_done: req=%0b writes=%0d expected 0 1", wr_req, wr_count - base);
    end
    send_byte(8'hF0, 7'h20);
    send_byte(8'h1C, 7'h41);
    idle(3);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd0) || (last_data !== 7'h41)) begin
      errors++;
      $display("FAIL basic_write: writes=%0d addr=%0d data=%0h expected 1 0 41",
               wr_count - base, last_addr, last_data);
    end
    check_cursor("basic_cursor", 0, 1);
    // Space key is printable even though its ASCII is 0x20; 0x05 is not.
    base = wr_count;
    send_byte(8'h05, 7'h20);
    idle(2);
    send_byte(8'h29, 7'h20);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd1) || (last_data !== 7'h20)) begin
      errors++;
      $display("FAIL space_key: writes=%0d addr=%0d data=%0h expected 1 1 20",
               wr_count - base, last_addr, last_data);
    end
    check_cursor("space_cursor", 0, 2);
  endtask

  task automatic test_wrap();
    int base;
    wr_ack = 1'b1;
    go_to(0, 79);
    check_cursor("goto_0_79", 0, 79);
    base = wr_count;
    send_byte(8'h1B, 7'h53);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd79) || (last_data !== 7'h53)) begin
      errors++;
      $display("FAIL wrap_row: writes=%0d addr=%0d data=%0h expected 1 79 53",
               wr_count - base, last_addr, last_data);
    end
    check_cursor("wrap_row_cursor", 1, 0);
    go_to(59, 79);
    base = wr_count;
    send_byte(8'h1C, 7'h41);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd4799)) begin
      errors++;
      $display("FAIL wrap_screen: writes=%0d addr=%0d expected 1 4799", wr_count - base, last_addr);
    end
    check_cursor("wrap_screen_cursor", 0, 0);
  endtask

  task automatic test_backspace();
    int base;
    wr_ack = 1'b1;
    go_to(1, 0);
    base = wr_count;
    send_byte(8'h66, 7'h08);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd79) || (last_data !== 7'h20)) begin
      errors++;
      $display("FAIL bs_row: writes=%0d addr=%0d data=%0h expected 1 79 20",
               wr_count - base, last_addr, last_data);
    end
    check_cursor("bs_row_cursor", 0, 79);
    send_byte(8'h66, 7'h08);
    idle(2);
    checks++;
    if (last_addr !== 13'd78) begin
      errors++;
      $display("FAIL bs_col: addr=%0d expected 78", last_addr);
    end
    check_cursor("bs_col_cursor", 0, 78);
    do_reset();
    base = wr_count;
    send_byte(8'h66, 7'h08);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd0) || (last_data !== 7'h20)) begin
      errors++;
      $display("FAIL bs_home: writes=%0d addr=%0d data=%0h expected 1 0 20",
               wr_count - base, last_addr, last_data);
    end
    check_cursor("bs_home_cursor", 0, 0);
  endtask

  task automatic test_stall();
    int base;
    int bad;
    wr_ack = 1'b0;
    go_to(0, 5);
    base = wr_count;
    bad  = 0;
    send_byte(8'h1C, 7'h41);
    for (int i = 0; i < 5; i++) begin
      if ((wr_req !== 1'b1) || (wr_addr !== 13'd5) || (wr_data !== 7'h41) || (scan_ready !== 1'b0))
        bad++;
      if (i == 1) begin
        scan_valid = 1'b1;
        scan_data  = 8'h16;
        ascii_in   = 7'h31;
      end
      @(negedge clk);
      scan_valid = 1'b0;
      if (i == 1) begin
        checks++;
        if (scan_drop !== 1'b1) begin
          errors++;
          $display("FAIL stall_drop: scan_drop=%0b expected 1", scan_drop);
        end
      end
      if (i == 2) begin
        checks++;
        if (scan_drop !== 1'b0) begin
          errors++;
          $display("FAIL stall_drop_end: scan_drop=%0b expected 0", scan_drop);
        end
      end
    end
    checks++;
    if ((bad != 0) || (wr_count != base)) begin
      errors++;
      $display("FAIL stall_hold: unstable cycles=%0d writes=%0d expected 0 0", bad, wr_count - base);
    end
    wr_ack = 1'b1;
    idle(3);
    checks++;
    if ((wr_count - base != 1) || (wr_req !== 1'b0) || (scan_ready !== 1'b1) || (last_addr !== 13'd5)) begin
      errors++;
      $display("FAIL stall_release: writes=%0d req=%0b rdy=%0b addr=%0d expected 1 0 1 5",
               wr_count - base, wr_req, scan_ready, last_addr);
    end
    check_cursor("stall_cursor", 0, 6);
  endtask

  task automatic test_ext();
    int base;
    wr_ack = 1'b1;
    do_reset();
    send_byte(8'hE0, 7'h20);
    send_byte(8'h6B, 7'h20);
    check_cursor("ext_left_clamp", 0, 0);
    send_byte(8'hE0, 7'h20);
    send_byte(8'h75, 7'h20);
    check_cursor("ext_up_clamp", 0, 0);
    go_to(59, 3);
    send_byte(8'hE0, 7'h20);
    send_byte(8'h72, 7'h20);
    check_cursor("ext_down_clamp", 59, 3);
    send_byte(8'hE0, 7'h20);
    send_byte(8'h75, 7'h20);
    send_byte(8'hE0, 7'h20);
    send_byte(8'h6B, 7'h20);
    check_cursor("ext_up_left", 58, 2);
    go_to(0, 79);
    send_byte(8'hE0, 7'h20);
    send_byte(8'h74, 7'h20);
    check_cursor("ext_right_clamp", 0, 79);
    go_to(5, 40);
    base = wr_count;
    send_byte(8'hE0, 7'h20);
    send_byte(8'hF0, 7'h20);
    send_byte(8'h72, 7'h20);
    check_cursor("ext_break", 5, 40);
    send_byte(8'h5A, 7'h0D);
    idle(2);
    check_cursor("enter", 6, 0);
    checks++;
    if (wr_count != base) begin
      errors++;
      $display("FAIL ext_no_write: writes=%0d expected 0", wr_count - base);
    end
    // Back in IDLE after the extended break: a key writes normally.
    send_byte(8'h1C, 7'h61);
    idle(2);
    checks++;
    if ((wr_count - base != 1) || (last_addr !== 13'd480) || (last_data !== 7'h61)) begin
      errors++;
      $display("FAIL after_ext: writes=%0d addr=%0d data=%0h expected 1 480 61",
               wr_count - base, last_addr, last_data);
    end
  endtask

  task automatic test_reset_mid_write();
    wr_ack = 1'b0;
    go_to(2, 2);
    send_byte(8'h1C, 7'h41);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: wr_req=%0b expected 0", wr_req);
    end
    check_cursor("reset_mid_cursor", 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    wr_ack = 1'b1;
    idle(2);
  endtask

`ifdef NOTEPAD_CLEAR_ON_ESC_EN
  task automatic test_clear();
    int base;
    int n;
    wr_ack = 1'b1;
    go_to(3, 4);
    base     = wr_count;
    clr_next = 0;
    clr_bad  = 0;
    send_byte(8'h76, 7'h1B);
    n = 0;
    while ((wr_req === 1'b1) && (n < 6000)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((wr_count - base != 4800) || (clr_bad != 0) || (scan_ready !== 1'b1) || (last_addr !== 13'd4799)) begin
      errors++;
      $display("FAIL clear: writes=%0d bad=%0d rdy=%0b last=%0d expected 4800 0 1 4799",
               wr_count - base, clr_bad, scan_ready, last_addr);
    end
    check_cursor("clear_cursor", 0, 0);
    send_byte(8'h76, 7'h1B);
    idle(10);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (wr_req !== 1'b0) begin
      errors++;
      $display("FAIL clear_reset: wr_req=%0b expected 0", wr_req);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask
`endif

  initial begin
    resetn     = 1'b0;
    scan_valid = 1'b0;
    scan_data  = 8'h00;
    ascii_in   = 7'h00;
    wr_ack     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backspace();
    test_stall();
    test_ext();
    test_reset_mid_write();
`ifdef NOTEPAD_CLEAR_ON_ESC_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
